// File: rtl/instr_issue_if.sv
// Instruction issue bus: program-memory fetch port and control-unit issue port.
// master = issue unit, slave = memory / control-unit side.
interface instr_issue_if #(
    parameter int AW = 8
);
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_valid;
    logic [31:0]   mem_rdata;
    logic [31:0]   ir;
    logic          cs;
    logic          ready;

    modport master (
        output mem_req, mem_addr, ir, cs,
        input  mem_valid, mem_rdata, ready
    );

    modport slave (
        input  mem_req, mem_addr, ir, cs,
        output mem_valid, mem_rdata, ready
    );
endinterface

// File: rtl/instr_issue.sv
// Instruction fetch/issue unit with a 2-entry prefetch FIFO and HALT detection.
// Define ISSUE_TIMEOUT_EN to add a sticky 'timeout' output that halts on a stuck ready.
module instr_issue #(
    parameter int AW          = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          halted,
`ifdef ISSUE_TIMEOUT_EN
    output logic          timeout,
`endif
    instr_issue_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q;
    logic [31:0]   fifo_mem [2];
    logic          rd_ptr, wr_ptr;
    logic [1:0]    count;
    logic          outstanding;
    logic          cs_q;
    logic [31:0]   ir_q;

    logic go, push, pop, head_halt, tmo_hit, flush, fetch_go;

    always_comb begin
        go        = start && (state_q != RUN);
        push      = (state_q == RUN) && outstanding && bus.mem_valid;
        pop       = (state_q == RUN) && cs_q && bus.ready;
        // An unissued head with opcode F stops the unit instead of being issued.
        head_halt = (state_q == RUN) && !cs_q && (count != 2'd0) &&
                    (fifo_mem[rd_ptr][31:28] == 4'hF);
        flush     = head_halt || tmo_hit;
        fetch_go  = (state_q == RUN) && !outstanding && (count != 2'd2) && !flush;

        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (flush) state_d = HALT;
            HALT:    if (start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= '0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            count       <= 2'd0;
            outstanding <= 1'b0;
            cs_q        <= 1'b0;
            ir_q        <= '0;
        end else if (go) begin
            pc_q        <= start_addr;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            count       <= 2'd0;
            outstanding <= 1'b0;
            cs_q        <= 1'b0;
        end else if (flush) begin
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            count       <= 2'd0;
            outstanding <= 1'b0;
            cs_q        <= 1'b0;
        end else begin
            if (fetch_go) begin
                pc_q        <= pc_q + 1'b1;
                outstanding <= 1'b1;
            end else if (push) begin
                outstanding <= 1'b0;
            end
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
            // Dropping cs on pop guarantees one idle cycle before the next issue.
            if (pop) begin
                cs_q <= 1'b0;
            end else if (!cs_q && (count != 2'd0) && (state_q == RUN)) begin
                cs_q <= 1'b1;
                ir_q <= fifo_mem[rd_ptr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= bus.mem_rdata;
    end

`ifdef ISSUE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt;
    logic          timeout_q;

    assign tmo_hit = (state_q == RUN) && cs_q && !bus.ready &&
                     (tmo_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt   <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (go)           timeout_q <= 1'b0;
            else if (tmo_hit) timeout_q <= 1'b1;
            if (cs_q && !bus.ready && !tmo_hit) tmo_cnt <= tmo_cnt + 1'b1;
            else                                tmo_cnt <= '0;
        end
    end

    assign timeout = timeout_q;
`else
    assign tmo_hit = 1'b0;
`endif

    assign bus.mem_req  = fetch_go;
    assign bus.mem_addr = pc_q;
    assign bus.cs       = cs_q;
    assign bus.ir       = ir_q;
    assign pc           = pc_q;
    assign busy         = (state_q == RUN);
    assign halted       = (state_q == HALT);

endmodule

// File: tb/tb_instr_issue.sv
// Scoreboard bench for instr_issue: expected issue words are queued by the stimulus,
// a negedge monitor pops and compares them and checks every fetch address.
module tb_instr_issue;
    localparam int AW = 8;
`ifdef ISSUE_TIMEOUT_EN
    localparam int TCYC = 4;
`else
    localparam int TCYC = 255;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] pc;
    logic          busy;
    logic          halted;
`ifdef ISSUE_TIMEOUT_EN
    logic          timeout;
`endif

    logic          cu_auto;
    logic          inject_valid;
    logic [31:0]   mem [256];

    logic [31:0]   exp_q [$];
    logic [31:0]   cur_exp;
    logic [AW-1:0] exp_addr;
    logic          cs_prev, ready_prev;
    int            checks = 0;
    int            failures = 0;
    int            issued = 0;
    int            req_count = 0;
    int            base;
    int            cs_cycles;

    instr_issue_if #(.AW(AW)) bus ();

    instr_issue #(.AW(AW), .TIMEOUT_CYC(TCYC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .pc         (pc),
        .busy       (busy),
        .halted     (halted),
`ifdef ISSUE_TIMEOUT_EN
        .timeout    (timeout),
`endif
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // Program memory with one-cycle read latency; inject_valid forces a stray response.
    always @(posedge clk) begin
        bus.mem_valid <= bus.mem_req || inject_valid;
        bus.mem_rdata <= inject_valid ? 32'hDEAD_BEEF : mem[bus.mem_addr];
    end

    // Control unit answers ready the cycle after it sees cs, unless stalled.
    always @(posedge clk) begin
        bus.ready <= cu_auto && bus.cs && !bus.ready;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] addr, input int n_good, input int n_expect);
        logic [7:0] a;
        for (int i = 0; i < n_good; i++) begin
            a = addr + 8'(i);
            mem[a] = {8'hA5, 8'(i), 8'h3C, a};
            if (i < n_expect) exp_q.push_back(mem[a]);
        end
        a = addr + 8'(n_good);
        mem[a] = 32'hF000_0000;
        @(posedge clk);
        #1;
        start_addr = addr;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
    endtask

    task automatic waitHalted(input string name);
        int n = 0;
        while (!halted && n < 400) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, 32'(halted), 32'd1);
    endtask

    task automatic waitCs(input string name);
        int n = 0;
        @(negedge clk);
        while (!bus.cs && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, 32'(bus.cs), 32'd1);
    endtask

    // Monitor: fetch address model, issue scoreboard, ir stability and cs handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            cs_prev    = 1'b0;
            ready_prev = 1'b0;
        end else begin
            if (start) exp_addr = start_addr;
            if (bus.mem_req) begin
                checkOutput("mem_addr", 32'(bus.mem_addr), 32'(exp_addr));
                exp_addr = exp_addr + 8'd1;
                req_count++;
            end
            if (bus.cs && !cs_prev) begin
                if (exp_q.size() == 0) begin
                    checkOutput("issue_with_empty_queue", 32'(exp_q.size()), 32'd1);
                end else begin
                    cur_exp = exp_q.pop_front();
                    checkOutput("ir_issue", bus.ir, cur_exp);
                    issued++;
                end
            end else if (bus.cs) begin
                checkOutput("ir_stable", bus.ir, cur_exp);
            end
            if (cs_prev && ready_prev) checkOutput("cs_drop_after_ready", 32'(bus.cs), 32'd0);
            cs_prev    = bus.cs;
            ready_prev = bus.ready;
        end
    end

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        start_addr   = '0;
        cu_auto      = 1'b1;
        inject_valid = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_cs", 32'(bus.cs), 32'd0);
        checkOutput("rst_mem_req", 32'(bus.mem_req), 32'd0);
        checkOutput("rst_ir", bus.ir, 32'd0);
        checkOutput("rst_pc", 32'(pc), 32'd0);
        checkOutput("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_halted", 32'(halted), 32'd0);
`ifdef ISSUE_TIMEOUT_EN
        checkOutput("rst_timeout", 32'(timeout), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] in-order issue from 0x10");
        applyStimulus(8'h10, 4, 4);
        checkOutput("busy_in_run", 32'(busy), 32'd1);
        waitHalted("halt_a");
        checkOutput("busy_after_halt_a", 32'(busy), 32'd0);
        checkOutput("cs_after_halt_a", 32'(bus.cs), 32'd0);
        checkOutput("drained_a", 32'(exp_q.size()), 32'd0);

        $display("[TB] halt word at 0x12");
        base = req_count;
        applyStimulus(8'h10, 2, 2);
        waitHalted("halt_b");
        repeat (10) @(negedge clk);
        checkOutput("fetch_count_b", 32'(req_count - base), 32'd3);
        checkOutput("cs_after_halt_b", 32'(bus.cs), 32'd0);
        checkOutput("pc_after_halt_b", 32'(pc), 32'h13);
        checkOutput("drained_b", 32'(exp_q.size()), 32'd0);

`ifdef ISSUE_TIMEOUT_EN
        $display("[TB] ready stuck low, timeout path");
        cu_auto = 1'b0;
        applyStimulus(8'h50, 2, 1);
        waitCs("cs_rise_t");
        cs_cycles = 0;
        while (bus.cs && cs_cycles < 20) begin
            cs_cycles++;
            @(negedge clk);
        end
        checkOutput("timeout_cs_cycles", 32'(cs_cycles), 32'd4);
        checkOutput("timeout_flag", 32'(timeout), 32'd1);
        checkOutput("timeout_halted", 32'(halted), 32'd1);
        checkOutput("timeout_cs", 32'(bus.cs), 32'd0);
        cu_auto = 1'b1;
        applyStimulus(8'h58, 2, 2);
        checkOutput("timeout_cleared", 32'(timeout), 32'd0);
        waitHalted("halt_t");
        checkOutput("drained_t", 32'(exp_q.size()), 32'd0);
`else
        $display("[TB] ready held low for 20 cycles");
        cu_auto = 1'b0;
        base = req_count;
        applyStimulus(8'h40, 4, 4);
        waitCs("cs_rise_c");
        repeat (5) @(negedge clk);
        inject_valid = 1'b1;
        @(negedge clk);
        inject_valid = 1'b0;
        repeat (14) @(negedge clk);
        checkOutput("fetch_count_stall", 32'(req_count - base), 32'd2);
        checkOutput("cs_held", 32'(bus.cs), 32'd1);
        checkOutput("pc_stall", 32'(pc), 32'h42);
        cu_auto = 1'b1;
        waitHalted("halt_c");
        checkOutput("drained_c", 32'(exp_q.size()), 32'd0);
`endif

        $display("[TB] address wrap from 0xFE");
        base = req_count;
        applyStimulus(8'hFE, 3, 3);
        waitHalted("halt_d");
        checkOutput("pc_wrap", 32'(pc), 32'h02);
        checkOutput("fetch_count_wrap", 32'(req_count - base), 32'd4);
        checkOutput("drained_d", 32'(exp_q.size()), 32'd0);

        $display("[TB] reset mid-issue with fetch outstanding");
        cu_auto = 1'b0;
        applyStimulus(8'h60, 2, 1);
        waitCs("cs_rise_e");
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_cs", 32'(bus.cs), 32'd0);
        checkOutput("arst_mem_req", 32'(bus.mem_req), 32'd0);
        checkOutput("arst_pc", 32'(pc), 32'd0);
        checkOutput("arst_mem_addr", 32'(bus.mem_addr), 32'd0);
        checkOutput("arst_ir", bus.ir, 32'd0);
        checkOutput("arst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        inject_valid = 1'b1;
        @(negedge clk);
        inject_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        inject_valid = 1'b1;
        @(negedge clk);
        inject_valid = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("idle_halted", 32'(halted), 32'd0);
        checkOutput("idle_cs", 32'(bus.cs), 32'd0);

        $display("[TB] restart after reset");
        cu_auto = 1'b1;
        applyStimulus(8'h70, 2, 2);
        waitHalted("halt_f");
        checkOutput("drained_f", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
